// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, aligns and extends load data,
// keeps load data stable across write-back stalls, and feeds the decode bypass.
module mem_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_to_mem_valid,
  output logic          o_mem_ready,
  input  logic [3:0]    ex_to_mem_mem_re,
  input  logic [DW-1:0] ex_to_mem_alu_res,
  input  logic [RW-1:0] ex_to_mem_rf_waddr,
  input  logic          ex_to_mem_rf_we,
  input  logic [DW-1:0] ex_to_mem_pc,
  input  logic [DW-1:0] ex_to_mem_inst,
  input  logic [DW-1:0] dsram_rdata,
  input  logic          i_wb_ready,
  output logic          mem_to_wb_valid,
  output logic          mem_active,
  output logic [DW-1:0] mem_to_wb_rf_wdata,
  output logic [RW-1:0] mem_to_wb_rf_waddr,
  output logic          mem_to_wb_rf_we,
  output logic [DW-1:0] mem_to_wb_pc,
  output logic [DW-1:0] mem_to_wb_inst,
  output logic          mem_fwd_we,
  output logic [RW-1:0] mem_fwd_waddr,
  output logic [DW-1:0] mem_fwd_wdata
);

  typedef enum logic [1:0] {EMPTY, FRESH, HELD} hold_t;

  hold_t         state_p0;
  logic          vld_p0;
  logic [3:0]    mem_re_p0;
  logic [DW-1:0] alu_res_p0;
  logic [RW-1:0] rf_waddr_p0;
  logic          rf_we_p0;
  logic [DW-1:0] pc_p0;
  logic [DW-1:0] inst_p0;
  logic [DW-1:0] hold_p0;

  logic          capture;
  logic          drain;
  logic          cap_load;
  logic [DW-1:0] raw_word;
  logic [DW-1:0] wdata;

  function automatic logic [DW-1:0] load_ext(input logic [9:0] op, input logic [1:0] a,
                                             input logic [DW-1:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      10'h0A0: load_ext = {{(DW-8){b[7]}}, b};
      10'h0A8: load_ext = {{(DW-8){1'b0}}, b};
      10'h0A1: load_ext = {{(DW-16){h[15]}}, h};
      10'h0A9: load_ext = {{(DW-16){1'b0}}, h};
      default: load_ext = w;
    endcase
  endfunction

  assign o_mem_ready = !vld_p0 | i_wb_ready;
  assign capture     = ex_to_mem_valid & o_mem_ready;
  assign drain       = vld_p0 & i_wb_ready;
  assign cap_load    = capture & (ex_to_mem_mem_re != 4'd0);

  // p0: pipeline register and load-hold state
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p0      <= 1'b0;
      state_p0    <= EMPTY;
      mem_re_p0   <= '0;
      alu_res_p0  <= '0;
      rf_waddr_p0 <= '0;
      rf_we_p0    <= 1'b0;
      pc_p0       <= '0;
      inst_p0     <= '0;
      hold_p0     <= '0;
    end else begin
      if (capture) begin
        vld_p0      <= 1'b1;
        mem_re_p0   <= ex_to_mem_mem_re;
        alu_res_p0  <= ex_to_mem_alu_res;
        rf_waddr_p0 <= ex_to_mem_rf_waddr;
        rf_we_p0    <= ex_to_mem_rf_we;
        pc_p0       <= ex_to_mem_pc;
        inst_p0     <= ex_to_mem_inst;
      end else if (drain) begin
        vld_p0 <= 1'b0;
      end
      // The SRAM word is only valid in the first cycle; a stall must snapshot it.
      case (state_p0)
        EMPTY: if (cap_load) state_p0 <= FRESH;
        FRESH: begin
          if (drain) begin
            state_p0 <= cap_load ? FRESH : EMPTY;
          end else begin
            hold_p0  <= dsram_rdata;
            state_p0 <= HELD;
          end
        end
        HELD:    if (drain) state_p0 <= cap_load ? FRESH : EMPTY;
        default: state_p0 <= EMPTY;
      endcase
    end
  end

  assign raw_word = (state_p0 == HELD) ? hold_p0 : dsram_rdata;
  assign wdata    = (mem_re_p0 != 4'd0) ? load_ext(inst_p0[31:22], alu_res_p0[1:0], raw_word)
                                        : alu_res_p0;

  assign mem_to_wb_valid    = vld_p0;
  assign mem_active         = vld_p0;
  assign mem_to_wb_rf_wdata = wdata;
  assign mem_to_wb_rf_waddr = rf_waddr_p0;
  assign mem_to_wb_rf_we    = vld_p0 & rf_we_p0;
  assign mem_to_wb_pc       = pc_p0;
  assign mem_to_wb_inst     = inst_p0;
  assign mem_fwd_we         = vld_p0 & rf_we_p0;
  assign mem_fwd_waddr      = rf_waddr_p0;
  assign mem_fwd_wdata      = wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized traffic checked against a
// transaction-level model of the stage (one slot, load word taken in its first cycle).
module tb_mem_stage;
  localparam int DW = 32;
  localparam int RW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          ex_to_mem_valid = 1'b0;
  logic          o_mem_ready;
  logic [3:0]    ex_to_mem_mem_re = '0;
  logic [DW-1:0] ex_to_mem_alu_res = '0;
  logic [RW-1:0] ex_to_mem_rf_waddr = '0;
  logic          ex_to_mem_rf_we = 1'b0;
  logic [DW-1:0] ex_to_mem_pc = '0;
  logic [DW-1:0] ex_to_mem_inst = '0;
  logic [DW-1:0] dsram_rdata = '0;
  logic          i_wb_ready = 1'b0;
  logic          mem_to_wb_valid;
  logic          mem_active;
  logic [DW-1:0] mem_to_wb_rf_wdata;
  logic [RW-1:0] mem_to_wb_rf_waddr;
  logic          mem_to_wb_rf_we;
  logic [DW-1:0] mem_to_wb_pc;
  logic [DW-1:0] mem_to_wb_inst;
  logic          mem_fwd_we;
  logic [RW-1:0] mem_fwd_waddr;
  logic [DW-1:0] mem_fwd_wdata;

  mem_stage #(.DW(DW), .RW(RW)) dut (
    .clk(clk), .rst(rst),
    .ex_to_mem_valid(ex_to_mem_valid), .o_mem_ready(o_mem_ready),
    .ex_to_mem_mem_re(ex_to_mem_mem_re), .ex_to_mem_alu_res(ex_to_mem_alu_res),
    .ex_to_mem_rf_waddr(ex_to_mem_rf_waddr), .ex_to_mem_rf_we(ex_to_mem_rf_we),
    .ex_to_mem_pc(ex_to_mem_pc), .ex_to_mem_inst(ex_to_mem_inst),
    .dsram_rdata(dsram_rdata), .i_wb_ready(i_wb_ready),
    .mem_to_wb_valid(mem_to_wb_valid), .mem_active(mem_active),
    .mem_to_wb_rf_wdata(mem_to_wb_rf_wdata), .mem_to_wb_rf_waddr(mem_to_wb_rf_waddr),
    .mem_to_wb_rf_we(mem_to_wb_rf_we), .mem_to_wb_pc(mem_to_wb_pc),
    .mem_to_wb_inst(mem_to_wb_inst), .mem_fwd_we(mem_fwd_we),
    .mem_fwd_waddr(mem_fwd_waddr), .mem_fwd_wdata(mem_fwd_wdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the instruction currently in the stage and its load word.
  bit          m_valid = 1'b0;
  bit          m_first = 1'b0;
  logic [3:0]  m_re;
  logic [31:0] m_alu, m_pc, m_inst, m_word;
  logic [4:0]  m_waddr;
  logic        m_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_load(input logic [31:0] inst, input logic [1:0] a,
                                           input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (inst[31:22])
      10'h0A0: return (b > 127) ? b - 256 : b;
      10'h0A8: return b;
      10'h0A1: return (h > 32767) ? h - 65536 : h;
      10'h0A9: return h;
      default: return w;
    endcase
  endfunction

  // Apply inputs for this cycle, then compare outputs against the model.
  task automatic drive(input logic r, input logic ev, input logic [3:0] re,
                       input logic [31:0] alu, input logic [4:0] wa, input logic we,
                       input logic [31:0] pc, input logic [31:0] inst,
                       input logic wbr, input logic [31:0] rd);
    logic [31:0] exp_wd;
    rst = r; ex_to_mem_valid = ev; ex_to_mem_mem_re = re; ex_to_mem_alu_res = alu;
    ex_to_mem_rf_waddr = wa; ex_to_mem_rf_we = we; ex_to_mem_pc = pc;
    ex_to_mem_inst = inst; i_wb_ready = wbr; dsram_rdata = rd;
    #1;
    if (m_valid && m_first) m_word = rd;
    chk("valid", mem_to_wb_valid, m_valid);
    chk("active", mem_active, m_valid);
    chk("ready", o_mem_ready, !m_valid || wbr);
    chk("we", mem_to_wb_rf_we, m_valid & m_we);
    chk("fwd_we", mem_fwd_we, m_valid & m_we);
    if (m_valid) begin
      exp_wd = (m_re != 0) ? exp_load(m_inst, m_alu[1:0], m_word) : m_alu;
      chk("wdata", mem_to_wb_rf_wdata, exp_wd);
      chk("fwd_wdata", mem_fwd_wdata, exp_wd);
      chk("waddr", mem_to_wb_rf_waddr, m_waddr);
      chk("fwd_waddr", mem_fwd_waddr, m_waddr);
      chk("pc", mem_to_wb_pc, m_pc);
      chk("inst", mem_to_wb_inst, m_inst);
    end
  endtask

  task automatic idle(input logic r, input logic wbr, input logic [31:0] rd);
    drive(r, 1'b0, 4'h0, 32'h0, 5'd0, 1'b0, 32'h0, 32'h0, wbr, rd);
  endtask

  task automatic tick();
    bit rdy;
    @(posedge clk);
    if (!rst) begin
      m_valid = 1'b0;
    end else begin
      rdy = !m_valid || i_wb_ready;
      if (ex_to_mem_valid && rdy) begin
        m_valid = 1'b1; m_first = 1'b1;
        m_re = ex_to_mem_mem_re; m_alu = ex_to_mem_alu_res; m_pc = ex_to_mem_pc;
        m_inst = ex_to_mem_inst; m_waddr = ex_to_mem_rf_waddr; m_we = ex_to_mem_rf_we;
      end else if (m_valid && i_wb_ready) begin
        m_valid = 1'b0;
      end else begin
        m_first = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  localparam logic [31:0] LDB  = 32'h0A0 << 22;
  localparam logic [31:0] LDBU = 32'h0A8 << 22;
  localparam logic [31:0] LDH  = 32'h0A1 << 22;
  localparam logic [31:0] LDHU = 32'h0A9 << 22;
  localparam logic [31:0] LDW  = 32'h0A2 << 22;

  initial begin
    logic [9:0] ops [6];
    ops = '{10'h0A0, 10'h0A8, 10'h0A1, 10'h0A9, 10'h0A2, 10'h1FF};
    @(negedge clk);

    // Reset, then an ALU passthrough
    idle(0, 1, 0); tick();
    idle(0, 1, 0); tick();
    drive(1, 1, 4'h0, 32'h12345678, 5'd5, 1, 32'h100, 32'h0, 1, 0);
    chk("rst_valid", mem_to_wb_valid, 0);
    chk("rst_ready", o_mem_ready, 1);
    tick();
    idle(1, 1, 0);
    chk("alu_wdata", mem_to_wb_rf_wdata, 32'h12345678);
    chk("alu_waddr", mem_to_wb_rf_waddr, 5);
    chk("alu_we", mem_to_wb_rf_we, 1);
    chk("alu_fwd_we", mem_fwd_we, 1);
    tick();

    // Sub-word loads, back to back
    drive(1, 1, 4'h1, 32'h1003, 5'd1, 1, 32'h200, LDB, 1, 0); tick();
    drive(1, 1, 4'h1, 32'h1003, 5'd2, 1, 32'h204, LDBU, 1, 32'h80FF_0000);
    chk("ld_b", mem_to_wb_rf_wdata, 32'hFFFFFF80); tick();
    drive(1, 1, 4'h3, 32'h1002, 5'd3, 1, 32'h208, LDH, 1, 32'h80FF_0000);
    chk("ld_bu", mem_to_wb_rf_wdata, 32'h00000080); tick();
    drive(1, 1, 4'h3, 32'h1002, 5'd4, 1, 32'h20C, LDHU, 1, 32'h8001_1234);
    chk("ld_h", mem_to_wb_rf_wdata, 32'hFFFF8001); tick();
    idle(1, 1, 32'h8001_1234);
    chk("ld_hu", mem_to_wb_rf_wdata, 32'h00008001); tick();

    // Stall hold: SRAM word changes while write-back is stalled
    drive(1, 1, 4'hF, 32'h2000, 5'd6, 1, 32'h300, LDW, 1, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 4'h0, 32'h55, 5'd7, 1, 32'h304, 32'h0, 0,
            (i == 0) ? 32'hCAFEF00D : 32'hDEADBEEF);
      chk("stall_wdata", mem_to_wb_rf_wdata, 32'hCAFEF00D);
      chk("stall_valid", mem_to_wb_valid, 1);
      chk("stall_ready", o_mem_ready, 0);
      tick();
    end
    idle(1, 1, 32'hDEADBEEF);
    chk("stall_drain", mem_to_wb_rf_wdata, 32'hCAFEF00D); tick();
    idle(1, 1, 0);
    chk("drained", mem_to_wb_valid, 0); tick();

    // Back-to-back ALU ops, no bubbles
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 4'h0, 32'hA0 + i, 5'(i + 1), 1, 32'h400 + 4 * i, 32'h0, 1, 0);
      if (i > 0) begin
        chk("b2b_valid", mem_to_wb_valid, 1);
        chk("b2b_pc", mem_to_wb_pc, 32'h400 + 4 * (i - 1));
      end
      tick();
    end
    idle(1, 1, 0);
    chk("b2b_last_pc", mem_to_wb_pc, 32'h40C); tick();

    // Drain and capture while data is held
    drive(1, 1, 4'hF, 32'h3000, 5'd8, 1, 32'h500, LDW, 1, 0); tick();
    idle(1, 0, 32'hAAAA5555); tick();
    idle(1, 0, 32'h0);
    chk("held_pre", mem_to_wb_rf_wdata, 32'hAAAA5555); tick();
    drive(1, 1, 4'hF, 32'h3004, 5'd9, 1, 32'h504, LDW, 1, 32'h22222222);
    chk("held_old", mem_to_wb_rf_wdata, 32'hAAAA5555); tick();
    idle(1, 1, 32'h11111111);
    chk("held_new", mem_to_wb_rf_wdata, 32'h11111111); tick();

    // Reset during a stall discards the held load
    drive(1, 1, 4'hF, 32'h3008, 5'd10, 1, 32'h600, LDW, 1, 0); tick();
    idle(1, 0, 32'h5A5A5A5A); tick();
    idle(1, 0, 32'h0); tick();
    idle(0, 0, 32'h0); tick();
    drive(1, 1, 4'hF, 32'h300C, 5'd11, 1, 32'h604, LDW, 1, 32'h5A5A5A5A);
    chk("rstmid_valid", mem_to_wb_valid, 0);
    chk("rstmid_ready", o_mem_ready, 1);
    tick();
    drive(1, 1, 4'h0, 32'h0BADCAFE, 5'd12, 1, 32'h608, 32'h0, 1, 32'h77777777);
    chk("rstmid_load", mem_to_wb_rf_wdata, 32'h77777777); tick();
    idle(1, 1, 32'h5A5A5A5A);
    chk("rstmid_alu", mem_to_wb_rf_wdata, 32'h0BADCAFE); tick();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        r, ev, wbr, is_ld;
      logic [3:0]  re;
      logic [31:0] inst;
      r     = ($urandom_range(0, 59) != 0);
      ev    = ($urandom_range(0, 3) != 0);
      wbr   = ($urandom_range(0, 9) < 7);
      is_ld = $urandom_range(0, 1) == 1;
      re    = is_ld ? 4'($urandom_range(1, 15)) : 4'h0;
      inst  = is_ld ? {ops[$urandom_range(0, 5)], 22'($urandom)} : $urandom;
      drive(r, ev, re, $urandom, 5'($urandom), 1'($urandom), $urandom, inst, wbr, $urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back.
- Holds one instruction in a valid/ready pipeline register and accepts the synchronous data-SRAM read word issued by execute in the previous cycle.
- Aligns and sign/zero-extends load data, and selects the load result or the ALU result as the write-back value.
- Keeps load data stable across write-back stalls, and drives a bypass port back to decode.

Parameters:
- DW, 32, data/address width.
- RW, 5, register-file address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- ex_to_mem_valid  in  1  execute stage offers an instruction
- o_mem_ready  out  1  stage can accept this cycle (drives execute's i_mem_ready)
- ex_to_mem_mem_re  in  4  nonzero = load
- ex_to_mem_alu_res  in  DW  ALU/mul-div result; the memory address for loads
- ex_to_mem_rf_waddr  in  RW  destination register
- ex_to_mem_rf_we  in  1  register write enable
- ex_to_mem_pc  in  DW  pc
- ex_to_mem_inst  in  DW  instruction word
- dsram_rdata  in  DW  SRAM read word, valid the cycle after the execute read
- i_wb_ready  in  1  write-back can accept
- mem_to_wb_valid  out  1  instruction offered to write-back
- mem_active  out  1  stage holds a valid instruction
- mem_to_wb_rf_wdata  out  DW  final write-back data
- mem_to_wb_rf_waddr  out  RW  destination register
- mem_to_wb_rf_we  out  1  write enable, gated by valid
- mem_to_wb_pc  out  DW  pc
- mem_to_wb_inst  out  DW  instruction word
- mem_fwd_we  out  1  bypass valid (= mem_to_wb_rf_we)
- mem_fwd_waddr  out  RW  bypass register address
- mem_fwd_wdata  out  DW  bypass data (= mem_to_wb_rf_wdata)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low.
- Reset: with rst=0 at a clk edge, mem_valid=0, the hold state becomes EMPTY, and the pipeline register and hold register clear to 0.
  - Therefore mem_to_wb_valid, mem_active, mem_to_wb_rf_we and mem_fwd_we read 0; o_mem_ready reads 1.
  - Reset mid-operation discards any in-flight instruction and any held data.
- Handshake:
  - mem_ready_go=1 (fixed).
  - o_mem_ready = !mem_valid | i_wb_ready.
  - mem_to_wb_valid = mem_valid.
  - Capture when ex_to_mem_valid & o_mem_ready: the register loads all ex_to_mem_* fields and mem_valid<=1.
  - When mem_valid & i_wb_ready & !ex_to_mem_valid: mem_valid<=0.
  - Simultaneous drain and capture: the new instruction replaces the old in the same cycle, with no bubble.
  - Latency: 1 cycle from capture to output; throughput 1 instruction per cycle when unstalled.
- Load data hold, state machine on a load in the register:
  - EMPTY: no load present. On capture of a load go to FRESH, else stay.
  - FRESH: first cycle of a load; raw word = dsram_rdata.
    - Drained and a new load captured: stay FRESH.
    - Drained with no new load: go to EMPTY.
    - Not drained (i_wb_ready=0): latch dsram_rdata into the hold register and go to HELD.
  - HELD: raw word = hold register; dsram_rdata is ignored, because execute may have issued a newer read.
    - On drain go to FRESH if a load was captured, else EMPTY.
- Load extension: selected by inst[31:22], with offset a = alu_res[1:0].
  - 0x0A0 ld.b: sign-extend byte[a].
  - 0x0A8 ld.bu: zero-extend byte[a].
  - 0x0A1 ld.h: sign-extend the halfword at a[1]*16.
  - 0x0A9 ld.hu: zero-extend the halfword at a[1]*16.
  - Any other load opcode (ld.w): full word. Misaligned addresses are not detected; the offset bits are used as given.
- Write-back data: mem_to_wb_rf_wdata = extended load data when mem_re!=0, else alu_res.
- Write enable: mem_to_wb_rf_we = mem_valid & rf_we.
- Stores: pass through with rf_we as supplied (normally 0).
- Purely combinational from the register and hold state: all mem_to_wb_* outputs and the bypass port.

Test Plan:
- Reset and ALU passthrough: hold rst=0 for 2 cycles, then check valid=0 and o_mem_ready=1. Release; send an ALU op with res=0x12345678, waddr=5, we=1, wb_ready=1. Next cycle expect wdata=0x12345678, waddr=5, we=1, fwd_we=1.
- Byte loads: ld.b at addr 0x1003 with rdata 0x80FF_0000 -> wdata 0xFFFFFF80. ld.bu at the same addr -> 0x00000080. ld.h at 0x1002 with rdata 0x8001_1234 -> 0xFFFF8001. ld.hu -> 0x00008001.
- Stall hold: ld.w with rdata 0xCAFEF00D in the FRESH cycle, wb_ready=0 for 3 cycles. Change dsram_rdata to 0xDEADBEEF. Expect wdata to stay 0xCAFEF00D, valid=1 and o_mem_ready=0 throughout; after wb_ready=1 the instruction drains in that cycle.
- Back-to-back: 4 consecutive instructions with wb_ready=1 and ex valid every cycle. Expect 4 consecutive valid outputs in order, no bubbles, correct pc sequence.
- Drain and capture under hold: a load is HELD, then wb_ready=1 together with a new ld.w (rdata 0x11111111 next cycle). Expect the old held value output this cycle and 0x11111111 the next.
- Reset mid-stall: a load is HELD, then rst=0 for one edge. Expect valid=0 and state EMPTY; a subsequent ALU op gives the correct result with no stale data.
